// File: rtl/delay_line_pkg.sv
// Shared types and helpers for the valid-tagged, run-time-adjustable delay line.
package delay_line_pkg;

    // RUN: accepting input, delay fixed. DRAIN: input blocked until in-flight samples leave.
    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_e;

    // Stage payload width for the default two-channel, 16-bit configuration.
    localparam int STAGE_DATA_W = 32;

    typedef struct packed {
        logic                    valid;
        logic [STAGE_DATA_W-1:0] data;
    } stage_t;

    // Bits needed to encode a delay of 0..max_depth.
    function automatic int depth_w(input int max_depth);
        return $clog2(max_depth + 1);
    endfunction

endpackage

// File: rtl/delay_line_vld_store.sv
// Shift storage of MAX_DEPTH {valid, data} stages with enable, clear and a tap mux.
module delay_store
    import delay_line_pkg::*;
#(
    parameter int MAX_DEPTH = 16,
    parameter int WIDTH     = 32,
    parameter int DW        = depth_w(MAX_DEPTH)
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic                 in_valid_i,
    input  logic [WIDTH-1:0]     in_data_i,
    input  logic [DW-1:0]        tap_i,
    output logic [MAX_DEPTH-1:0] valid_vec_o,
    output logic                 tap_valid_o,
    output logic [WIDTH-1:0]     tap_data_o
);

    logic [MAX_DEPTH-1:0] vld_q;
    logic [WIDTH-1:0]     dat_q [MAX_DEPTH];

    // Clear wins over shifting; shifting only on enabled cycles.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            vld_q <= '0;
            for (int i = 0; i < MAX_DEPTH; i++) dat_q[i] <= '0;
        end else if (clr_i) begin
            vld_q <= '0;
            for (int i = 0; i < MAX_DEPTH; i++) dat_q[i] <= '0;
        end else if (en_i) begin
            vld_q[0] <= in_valid_i;
            dat_q[0] <= in_data_i;
            for (int i = 1; i < MAX_DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    // Tap at stage tap_i-1; a tap of 0 selects nothing (bypass is handled by the caller).
    always_comb begin
        tap_valid_o = 1'b0;
        tap_data_o  = '0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            if (tap_i == DW'(i + 1)) begin
                tap_valid_o = vld_q[i];
                tap_data_o  = vld_q[i] ? dat_q[i] : '0;
            end
        end
    end

    assign valid_vec_o = vld_q;

endmodule

// File: rtl/delay_line_vld.sv
// Multi-channel valid-tagged delay line whose delay can be changed safely at run time.
module delay_line_vld
    import delay_line_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int NUM_CH        = 2,
    parameter int MAX_DEPTH     = 16,
    parameter int DEFAULT_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           arst_n,
    input  logic                           en_in,
    input  logic                           flush_in,
    input  logic                           depth_load_in,
    input  logic [depth_w(MAX_DEPTH)-1:0]  depth_in,
    input  logic                           src_valid_in,
    output logic                           src_ready_out,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   src_data_in,
    output logic                           dst_valid_out,
    output logic [NUM_CH*DATA_WIDTH-1:0]   dst_data_out,
    output logic [depth_w(MAX_DEPTH)-1:0]  depth_out,
    output logic                           busy_out,
    output logic                           depth_err_out
);

    localparam int              W     = NUM_CH * DATA_WIDTH;
    localparam int              DW    = depth_w(MAX_DEPTH);
    localparam logic [DW-1:0]   MAX_D = DW'(MAX_DEPTH);
    localparam logic [DW-1:0]   DEF_D = DW'(DEFAULT_DEPTH);

    state_e          state_q;
    logic            ready_q;
    logic [DW-1:0]   depth_q;
    logic [DW-1:0]   pend_q;
    logic            err_q;

    logic            accept;
    logic            busy;
    logic            over;
    logic [DW-1:0]   req;
    logic [DW-1:0]   pend_eff;
    logic            load_chg;
    logic            run_apply;
    logic            apply;
    logic [MAX_DEPTH-1:0] valid_vec;
    logic [MAX_DEPTH-1:0] live_mask;
    logic            tap_valid;
    logic [W-1:0]    tap_data;

    assign accept = src_valid_in & ready_q & en_in;

    // Stages in front of the tap still hold samples that must reach the output.
    always_comb begin
        live_mask = '0;
        for (int i = 0; i < MAX_DEPTH; i++) live_mask[i] = (DW'(i) < depth_q);
        busy = |(valid_vec & live_mask);
    end

    // Depth request decode: clamp, detect a real change, decide immediate apply.
    always_comb begin
        over      = (depth_in > MAX_D);
        req       = over ? MAX_D : depth_in;
        pend_eff  = depth_load_in ? req : pend_q;
        load_chg  = depth_load_in & (req != depth_q);
        run_apply = (state_q == RUN) & load_chg & ~busy & ~accept;
        apply     = ~flush_in & (run_apply | ((state_q == DRAIN) & ~busy));
    end

    // Control FSM with depth, pending-depth and sticky error registers.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= RUN;
            ready_q <= 1'b1;
            depth_q <= DEF_D;
            pend_q  <= DEF_D;
            err_q   <= 1'b0;
        end else if (flush_in) begin
            // Flush discards any request arriving in the same cycle.
            if (state_q == DRAIN) depth_q <= pend_q;
            state_q <= RUN;
            ready_q <= 1'b1;
        end else begin
            if (depth_load_in && over) err_q <= 1'b1;
            case (state_q)
                RUN: begin
                    if (load_chg) begin
                        if (run_apply) begin
                            depth_q <= req;
                        end else begin
                            pend_q  <= req;
                            state_q <= DRAIN;
                            ready_q <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    pend_q <= pend_eff;
                    if (!busy) begin
                        depth_q <= pend_eff;
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Any depth change wipes the stages so stale entries past the old tap never surface.
    delay_store #(
        .MAX_DEPTH (MAX_DEPTH),
        .WIDTH     (W),
        .DW        (DW)
    ) u_store (
        .clk         (clk),
        .arst_n      (arst_n),
        .en_i        (en_in),
        .clr_i       (flush_in | apply),
        .in_valid_i  (accept),
        .in_data_i   (accept ? src_data_in : '0),
        .tap_i       (depth_q),
        .valid_vec_o (valid_vec),
        .tap_valid_o (tap_valid),
        .tap_data_o  (tap_data)
    );

    // Output select: zero delay bypasses storage, suppressed during a flush.
    always_comb begin
        dst_valid_out = 1'b0;
        dst_data_out  = '0;
        if (depth_q == '0) begin
            dst_valid_out = accept & ~flush_in;
            dst_data_out  = (accept & ~flush_in) ? src_data_in : '0;
        end else begin
            dst_valid_out = tap_valid;
            dst_data_out  = tap_data;
        end
    end

    assign src_ready_out = ready_q;
    assign depth_out     = depth_q;
    assign busy_out      = busy;
    assign depth_err_out = err_q;

endmodule

// File: tb/tb_delay_line_vld.sv
// Directed plus randomized bench for delay_line_vld against a queue-based reference.
module tb_delay_line_vld;
    import delay_line_pkg::*;

    localparam int MAXD = 16;
    localparam int DEFD = 8;

    logic        clk = 1'b0;
    logic        arst_n = 1'b1;
    logic        en_in = 1'b0;
    logic        flush_in = 1'b0;
    logic        depth_load_in = 1'b0;
    logic [4:0]  depth_in = '0;
    logic        src_valid_in = 1'b0;
    logic        src_ready_out;
    logic [31:0] src_data_in = '0;
    logic        dst_valid_out;
    logic [31:0] dst_data_out;
    logic [4:0]  depth_out;
    logic        busy_out;
    logic        depth_err_out;

    delay_line_vld #(
        .DATA_WIDTH    (16),
        .NUM_CH        (2),
        .MAX_DEPTH     (MAXD),
        .DEFAULT_DEPTH (DEFD)
    ) dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .en_in         (en_in),
        .flush_in      (flush_in),
        .depth_load_in (depth_load_in),
        .depth_in      (depth_in),
        .src_valid_in  (src_valid_in),
        .src_ready_out (src_ready_out),
        .src_data_in   (src_data_in),
        .dst_valid_out (dst_valid_out),
        .dst_data_out  (dst_data_out),
        .depth_out     (depth_out),
        .busy_out      (busy_out),
        .depth_err_out (depth_err_out)
    );

    always #5 clk = ~clk;

    // Reference: each in-flight sample remembers how many more enabled edges
    // until it is visible at the output (0 = visible now).
    typedef struct {
        logic [31:0] data;
        int          rem;
    } ent_t;

    ent_t mq[$];
    int   m_depth;
    int   m_pend;
    bit   m_drain;
    bit   m_err;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int cyc    = 0;
    int first_seen = 0;
    logic [31:0] first_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_depth = DEFD;
        m_pend  = DEFD;
        m_drain = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic check_outputs(input bit v, input logic [31:0] d, input bit e, input bit f);
        stage_t exp_o;
        bit     acc;
        acc = v & ~m_drain & e;
        exp_o.valid = 1'b0;
        exp_o.data  = '0;
        if (m_depth == 0) begin
            exp_o.valid = acc & ~f;
            exp_o.data  = exp_o.valid ? d : 32'h0;
        end else if (mq.size() > 0 && mq[0].rem == 0) begin
            exp_o.valid = 1'b1;
            exp_o.data  = mq[0].data;
        end
        chk("ready", {31'b0, src_ready_out}, {31'b0, ~m_drain});
        chk("dst_valid", {31'b0, dst_valid_out}, {31'b0, exp_o.valid});
        chk("dst_data", dst_data_out, exp_o.data);
        chk("busy", {31'b0, busy_out}, {31'b0, (mq.size() > 0)});
        chk("depth", {27'b0, depth_out}, 32'(m_depth));
        chk("depth_err", {31'b0, depth_err_out}, {31'b0, m_err});
        if (dst_valid_out && first_seen == 0) begin
            first_seen = cyc;
            first_data = dst_data_out;
        end
    endtask

    task automatic model_update(input bit v, input logic [31:0] d, input bit e,
                                input bit f, input bit ld, input int dep);
        bit acc, busy, applied;
        int req, old_depth;
        acc       = v & ~m_drain & e;
        busy      = (mq.size() > 0);
        req       = (dep > MAXD) ? MAXD : dep;
        old_depth = m_depth;
        applied   = 1'b0;
        if (f) begin
            mq.delete();
            if (m_drain) m_depth = m_pend;
            m_drain = 1'b0;
            return;
        end
        if (ld && dep > MAXD) m_err = 1'b1;
        if (!m_drain) begin
            if (ld && req != m_depth) begin
                if (!busy && !acc) begin
                    m_depth = req;
                    applied = 1'b1;
                end else begin
                    m_pend  = req;
                    m_drain = 1'b1;
                end
            end
        end else begin
            if (ld) m_pend = req;
            if (!busy) begin
                m_depth = m_pend;
                m_drain = 1'b0;
                applied = 1'b1;
            end
        end
        if (applied) begin
            mq.delete();
            return;
        end
        if (e) begin
            if (mq.size() > 0 && mq[0].rem == 0) void'(mq.pop_front());
            foreach (mq[i]) mq[i].rem--;
            if (acc && old_depth > 0) mq.push_back('{data: d, rem: old_depth - 1});
        end
    endtask

    // One clock: drive at posedge+1, check at negedge, advance model, wait for next edge.
    task automatic step(input bit v, input logic [31:0] d, input bit e,
                        input bit f, input bit ld, input int dep);
        cyc++;
        src_valid_in  = v;
        src_data_in   = d;
        en_in         = e;
        flush_in      = f;
        depth_load_in = ld;
        depth_in      = dep[4:0];
        @(negedge clk);
        check_outputs(v, d, e, f);
        model_update(v, d, e, f, ld, dep);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        src_valid_in  = 1'b0;
        src_data_in   = '0;
        en_in         = 1'b0;
        flush_in      = 1'b0;
        depth_load_in = 1'b0;
        depth_in      = '0;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_dst_valid"}, {31'b0, dst_valid_out}, 32'h0);
        chk({tag, "_dst_data"}, dst_data_out, 32'h0);
        chk({tag, "_depth"}, {27'b0, depth_out}, 32'(DEFD));
        chk({tag, "_ready"}, {31'b0, src_ready_out}, 32'h1);
        chk({tag, "_busy"}, {31'b0, busy_out}, 32'h0);
        chk({tag, "_err"}, {31'b0, depth_err_out}, 32'h0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;
    endtask

    function automatic logic [31:0] pat(input int k);
        return {k[15:0], k[15:0]};
    endfunction

    initial begin
        int nxt;
        bit e;
        model_reset();
        idle_inputs();

        // Power-on reset.
        #1 arst_n = 1'b0;
        @(posedge clk);
        #1;
        reset_checks("por");
        release_reset();

        // Default delay, back-to-back stream 1,2,3,...
        for (int i = 1; i <= 20; i++) step(1'b1, pat(i), 1'b1, 1'b0, 1'b0, 0);
        chk("first_out_step", 32'(first_seen), 32'd9);
        chk("first_out_data", first_data, 32'h0001_0001);

        // Stall: enable low for three cycles mid-stream.
        nxt = 21;
        for (int i = 0; i < 20; i++) begin
            e = !(i >= 5 && i < 8);
            step(1'b1, pat(nxt), e, 1'b0, 1'b0, 0);
            if (e) nxt++;
        end

        // Depth 8 -> 3 with five samples in flight.
        arst_n = 1'b0;
        #1;
        model_reset();
        idle_inputs();
        release_reset();
        for (int i = 1; i <= 5; i++) step(1'b1, pat(100 + i), 1'b1, 1'b0, 1'b0, 0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 3);
        chk("drain_ready_low", {31'b0, src_ready_out}, 32'h0);
        for (int i = 0; i < 16; i++) step(1'b1, pat(200 + i), 1'b1, 1'b0, 1'b0, 0);

        // Depth 0 bypass, then an over-range request.
        step(1'b1, pat(300), 1'b1, 1'b0, 1'b1, 0);
        for (int i = 1; i <= 8; i++) step(1'b1, pat(300 + i), 1'b1, 1'b0, 1'b0, 0);
        step(1'b1, pat(320), 1'b1, 1'b0, 1'b1, 20);
        for (int i = 1; i <= 4; i++) step(1'b1, pat(320 + i), 1'b1, 1'b0, 1'b0, 0);
        chk("ovr_depth", {27'b0, depth_out}, 32'd16);
        chk("ovr_err", {31'b0, depth_err_out}, 32'h1);
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 5);
        chk("err_sticky", {31'b0, depth_err_out}, 32'h1);

        // Flush while draining: four in flight, pending delay 2.
        arst_n = 1'b0;
        #1;
        model_reset();
        idle_inputs();
        release_reset();
        for (int i = 1; i <= 4; i++) step(1'b1, pat(400 + i), 1'b1, 1'b0, 1'b0, 0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 2);
        step(1'b1, pat(499), 1'b1, 1'b1, 1'b0, 0);
        chk("flush_depth", {27'b0, depth_out}, 32'd2);
        chk("flush_ready", {31'b0, src_ready_out}, 32'h1);
        chk("flush_busy", {31'b0, busy_out}, 32'h0);
        for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 0);
        for (int i = 1; i <= 6; i++) step(1'b1, pat(500 + i), 1'b1, 1'b0, 1'b0, 0);

        // Asynchronous reset in the middle of a stream.
        arst_n = 1'b0;
        #1;
        reset_checks("arst");
        model_reset();
        idle_inputs();
        release_reset();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit rv, re, rf, rl;
            int rd;
            rv = ($urandom_range(0, 99) < 70);
            re = ($urandom_range(0, 99) < 85);
            rf = ($urandom_range(0, 99) < 2);
            rl = ($urandom_range(0, 99) < 4);
            rd = $urandom_range(0, 20);
            step(rv, $urandom, re, rf, rl, rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
